// File: rtl/iz_pkg.sv
// Shared Q16.16 fixed-point helpers and constants for the Izhikevich neuron datapath.
// Holds the neuron model constants alongside the synaptic current front end.
package iz_pkg;
  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;
  localparam logic signed [Q_W-1:0] Q_ONE = 32'sd65536;

  // Izhikevich model constants, Q16.16
  localparam logic signed [Q_W-1:0] IZ_A      = 32'sd1311;
  localparam logic signed [Q_W-1:0] IZ_B      = 32'sd13107;
  localparam logic signed [Q_W-1:0] IZ_C      = -32'sd4259840;
  localparam logic signed [Q_W-1:0] IZ_D      = 32'sd524288;
  localparam logic signed [Q_W-1:0] IZ_V_PEAK = 32'sd1966080;
  localparam logic signed [Q_W-1:0] IZ_K1     = 32'sd2621;
  localparam logic signed [Q_W-1:0] IZ_K2     = 32'sd327680;
  localparam logic signed [Q_W-1:0] IZ_K3     = 32'sd9175040;

  function automatic logic signed [Q_W-1:0] sat_add(
    input logic signed [Q_W-1:0] a,
    input logic signed [Q_W-1:0] b,
    input logic signed [Q_W-1:0] lim
  );
    logic signed [Q_W+1:0] s;
    logic signed [Q_W+1:0] l;
    s = {{2{a[Q_W-1]}}, a} + {{2{b[Q_W-1]}}, b};
    l = {{2{lim[Q_W-1]}}, lim};
    if (s > l)
      sat_add = lim;
    else if (s < -l)
      sat_add = -lim;
    else
      sat_add = s[Q_W-1:0];
  endfunction

  function automatic logic signed [Q_W-1:0] q88_to_q1616(
    input logic signed [15:0] w
  );
    q88_to_q1616 = {{8{w[15]}}, w, 8'h00};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
// Produces a one-hot grant and a valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [AW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld
);
  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  // requests at or above the pointer take priority, else wrap to the lowest
  assign w_mask = ~((N'(1) << i_ptr) - N'(1));
  assign w_hi   = i_req & w_mask;
  assign w_sel  = (|w_hi) ? w_hi : i_req;
  assign o_gnt  = w_sel & (~w_sel + N'(1));
  assign o_vld  = |i_req;
endmodule

// File: rtl/synaptic_current_gen.sv
// Spike-to-current front end: latched spikes, round-robin weight service,
// decaying saturated accumulator and registered Q16.16 current output.
module synaptic_current_gen #(
  parameter int NUM_SYN      = 4,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 8,
  parameter logic signed [31:0] I_MAX = 32'sd13107200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_SYN-1:0]         syn_spike,
  input  logic                       w_wr_en,
  input  logic [$clog2(NUM_SYN)-1:0] w_wr_addr,
  input  logic [15:0]                w_wr_data,
  input  logic signed [31:0]         bias,
  output logic signed [31:0]         current,
  output logic [15:0]                drop_cnt
);
  import iz_pkg::*;

  localparam int AW = $clog2(NUM_SYN);
  localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  logic [NUM_SYN-1:0]      r_pend;
  logic [AW-1:0]           r_rr_ptr;
  logic [TW-1:0]           r_tick;
  logic signed [Q_W-1:0]   r_acc;
  logic signed [Q_W-1:0]   r_current;
  logic [15:0]             r_drop;
  logic signed [15:0]      r_w [NUM_SYN];

  logic [NUM_SYN-1:0]      w_gnt_oh;
  logic                    w_gnt_vld;
  logic                    w_srv;
  logic [AW-1:0]           w_gnt_idx;
  logic [AW-1:0]           w_ptr_n;
  logic [NUM_SYN-1:0]      w_clr;
  logic [NUM_SYN-1:0]      w_drop;
  logic [4:0]              w_ndrop;
  logic [16:0]             w_dsum;
  logic                    w_tick;
  logic signed [Q_W-1:0]   w_acc_d;
  logic signed [Q_W-1:0]   w_wadd;
  logic signed [Q_W-1:0]   w_acc_n;

  rr_arbiter #(
    .N  (NUM_SYN),
    .AW (AW)
  ) u_arb (
    .i_req (r_pend),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_oh),
    .o_vld (w_gnt_vld)
  );

  assign w_srv = enable & w_gnt_vld;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_SYN; i++)
      if (w_gnt_oh[i]) w_gnt_idx = AW'(i);
  end

  assign w_ptr_n = (w_gnt_idx == AW'(NUM_SYN - 1)) ? '0 : w_gnt_idx + 1'b1;

  // a spike on the synapse being served re-arms it instead of dropping
  assign w_clr  = w_srv ? w_gnt_oh : '0;
  assign w_drop = syn_spike & r_pend & ~w_clr;

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_SYN; i++)
      w_ndrop = w_ndrop + 5'(w_drop[i]);
  end

  assign w_dsum = {1'b0, r_drop} + 17'(w_ndrop);

  assign w_tick  = enable && (r_tick == TW'(DECAY_PERIOD - 1));
  assign w_acc_d = w_tick ? r_acc - (r_acc >>> DECAY_SHIFT) : r_acc;
  assign w_wadd  = w_srv ? q88_to_q1616(r_w[w_gnt_idx]) : '0;
  assign w_acc_n = enable ? sat_add(w_acc_d, w_wadd, I_MAX) : r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend    <= '0;
      r_rr_ptr  <= '0;
      r_tick    <= '0;
      r_acc     <= '0;
      r_current <= '0;
      r_drop    <= '0;
    end else begin
      r_pend    <= (r_pend & ~w_clr) | syn_spike;
      r_drop    <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
      r_acc     <= w_acc_n;
      r_current <= sat_add(w_acc_n, bias, I_MAX);
      if (w_srv)
        r_rr_ptr <= w_ptr_n;
      if (enable)
        r_tick <= w_tick ? '0 : r_tick + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SYN; i++)
        r_w[i] <= '0;
    end else if (w_wr_en && (int'(w_wr_addr) < NUM_SYN)) begin
      r_w[w_wr_addr] <= w_wr_data;
    end
  end

  assign current  = r_current;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_synaptic_current_gen.sv
// Directed bench for synaptic_current_gen with a queued expectation scoreboard.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_synaptic_current_gen;
  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [3:0]         syn_spike;
  logic               w_wr_en;
  logic [1:0]         w_wr_addr;
  logic [15:0]        w_wr_data;
  logic signed [31:0] bias;
  logic signed [31:0] current;
  logic [15:0]        drop_cnt;

  int total = 0;
  int bad   = 0;

  string       tq[$];
  int          kq[$];
  logic [31:0] eq[$];

  synaptic_current_gen #(
    .NUM_SYN      (4),
    .DECAY_SHIFT  (3),
    .DECAY_PERIOD (8),
    .I_MAX        (32'sd13107200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .syn_spike (syn_spike),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .bias      (bias),
    .current   (current),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_cur(input string t, input logic [31:0] v);
    tq.push_back(t);
    kq.push_back(0);
    eq.push_back(v);
  endtask

  task automatic exp_drop(input string t, input logic [15:0] v);
    tq.push_back(t);
    kq.push_back(1);
    eq.push_back({16'h0, v});
  endtask

  task automatic chk();
    string       t;
    int          k;
    logic [31:0] e;
    logic [31:0] o;
    while (eq.size() > 0) begin
      t = tq.pop_front();
      k = kq.pop_front();
      e = eq.pop_front();
      o = (k == 0) ? current : {16'h0, drop_cnt};
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", t, $signed(o), $signed(e));
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    w_wr_en   = 1'b1;
    w_wr_addr = a;
    w_wr_data = d;
    cyc();
    w_wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    syn_spike = '0;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    bias      = '0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    // single spike, then first decay tick and bias behaviour
    do_reset();
    exp_cur("rst_cur", 32'd0);
    exp_drop("rst_drop", 16'd0);
    chk();
    wr(2'd0, 16'h0A00);
    syn_spike = 4'b0001;
    cyc();
    syn_spike = '0;
    exp_cur("ss_before", 32'd0);
    chk();
    cyc();
    exp_cur("ss_after", 32'd655360);
    chk();
    cyc(4);
    exp_cur("pre_tick", 32'd655360);
    chk();
    cyc();
    exp_cur("decay1", 32'd573440);
    chk();
    bias = 32'sd13107200;
    cyc();
    exp_cur("bias_sat", 32'd13107200);
    chk();
    bias = '0;
    cyc();
    exp_cur("bias_off", 32'd573440);
    chk();

    // small positive residue stops at 7
    do_reset();
    wr(2'd0, 16'h0001);
    syn_spike = 4'b0001;
    cyc();
    syn_spike = '0;
    cyc();
    exp_cur("small_pos", 32'd256);
    chk();
    cyc(5);
    exp_cur("small_tick", 32'd224);
    chk();
    cyc(480);
    exp_cur("floor7", 32'd7);
    chk();
    cyc(8);
    exp_cur("floor7_hold", 32'd7);
    chk();

    // negative residue decays all the way to 0
    do_reset();
    wr(2'd0, 16'hFFFF);
    syn_spike = 4'b0001;
    cyc();
    syn_spike = '0;
    cyc();
    exp_cur("small_neg", -32'sd256);
    chk();
    cyc(5);
    exp_cur("neg_tick", -32'sd224);
    chk();
    cyc(480);
    exp_cur("neg_zero", 32'd0);
    chk();

    // round-robin over four simultaneous spikes
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'h0200);
    wr(2'd2, 16'h0300);
    wr(2'd3, 16'h0400);
    syn_spike = 4'b1111;
    cyc();
    syn_spike = '0;
    exp_cur("rr_idle", 32'd0);
    chk();
    enable = 1'b1;
    cyc();
    exp_cur("rr_g0", 32'd65536);
    chk();
    cyc();
    exp_cur("rr_g1", 32'd196608);
    chk();
    cyc();
    exp_cur("rr_g2", 32'd393216);
    chk();
    cyc();
    exp_cur("rr_g3", 32'd655360);
    chk();
    cyc();
    exp_cur("rr_done", 32'd655360);
    exp_drop("rr_drop", 16'd0);
    chk();

    // drop counting and re-arm during service
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'h0200);
    wr(2'd2, 16'h0400);
    syn_spike = 4'b0011;
    cyc();
    syn_spike = 4'b0100;
    cyc(2);
    syn_spike = '0;
    exp_drop("drop_one", 16'd1);
    chk();
    enable = 1'b1;
    cyc();
    exp_cur("dr_g0", 32'd65536);
    chk();
    cyc();
    exp_cur("dr_g1", 32'd196608);
    chk();
    syn_spike = 4'b0100;
    cyc();
    syn_spike = '0;
    exp_cur("dr_g2", 32'd458752);
    exp_drop("rearm_nodrop", 16'd1);
    chk();
    cyc();
    exp_cur("dr_g2_again", 32'd720896);
    chk();
    cyc();
    exp_cur("dr_idle", 32'd720896);
    chk();
    enable = 1'b0;
    syn_spike = 4'b1111;
    cyc(2);
    syn_spike = '0;
    exp_drop("drop_multi", 16'd5);
    chk();

    // write colliding with a grant uses the old weight
    do_reset();
    enable = 1'b0;
    wr(2'd1, 16'h0100);
    syn_spike = 4'b0010;
    cyc();
    syn_spike = '0;
    enable    = 1'b1;
    w_wr_en   = 1'b1;
    w_wr_addr = 2'd1;
    w_wr_data = 16'h0300;
    cyc();
    w_wr_en = 1'b0;
    exp_cur("wr_old", 32'd65536);
    chk();
    syn_spike = 4'b0010;
    cyc();
    syn_spike = '0;
    cyc();
    exp_cur("wr_new", 32'd262144);
    chk();

    // positive saturation
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h7FFF);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      syn_spike = 4'b0001;
      cyc();
      syn_spike = '0;
      cyc();
      exp_cur("sat_pos", (i == 0) ? 32'd8388352 : 32'd13107200);
      chk();
    end

    // negative saturation
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h8000);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      syn_spike = 4'b0001;
      cyc();
      syn_spike = '0;
      cyc();
      exp_cur("sat_neg", (i == 0) ? -32'sd8388608 : -32'sd13107200);
      chk();
    end

    // asynchronous reset in the middle of service
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'h0200);
    wr(2'd2, 16'h0300);
    wr(2'd3, 16'h0400);
    syn_spike = 4'b1111;
    cyc();
    syn_spike = '0;
    enable = 1'b1;
    cyc();
    exp_cur("mid_g0", 32'd65536);
    chk();
    reset = 1'b1;
    #1;
    exp_cur("async_rst", 32'd0);
    chk();
    cyc();
    reset  = 1'b0;
    enable = 1'b0;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'h0200);
    wr(2'd2, 16'h0300);
    wr(2'd3, 16'h0400);
    enable = 1'b1;
    cyc();
    exp_cur("post_rst1", 32'd0);
    chk();
    cyc();
    exp_cur("post_rst2", 32'd0);
    chk();

    // enable low freezes acc and tick counter, latching continues
    do_reset();
    enable = 1'b0;
    wr(2'd0, 16'h0A00);
    enable = 1'b1;
    syn_spike = 4'b0001;
    cyc();
    syn_spike = '0;
    cyc();
    exp_cur("en_g1", 32'd655360);
    chk();
    enable = 1'b0;
    cyc(5);
    syn_spike = 4'b0001;
    cyc();
    syn_spike = '0;
    bias = 32'sd65536;
    cyc();
    exp_cur("dis_bias", 32'd720896);
    chk();
    bias = '0;
    cyc(13);
    exp_cur("dis_hold", 32'd655360);
    chk();
    enable = 1'b1;
    cyc();
    exp_cur("en_g2", 32'd1310720);
    chk();
    cyc(4);
    exp_cur("en_pretick", 32'd1310720);
    chk();
    cyc();
    exp_cur("en_tick", 32'd1146880);
    exp_drop("en_drop", 16'd0);
    chk();

    // drop counter saturates
    do_reset();
    enable = 1'b0;
    syn_spike = 4'b1111;
    cyc(16400);
    syn_spike = '0;
    exp_drop("drop_sat", 16'hFFFF);
    chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
